// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state type and helpers for the display scan controller
package display_pkg;

   localparam logic [2:0] SEL_THOU  = 3'd4;
   localparam logic [2:0] SEL_HUND  = 3'd3;
   localparam logic [2:0] SEL_COLON = 3'd2;
   localparam logic [2:0] SEL_TENS  = 3'd1;
   localparam logic [2:0] SEL_ONES  = 3'd0;

   localparam logic [15:0] MAX_VALUE = 16'd9999;

   localparam logic [15:0] LZ_THOU = 16'd1000;
   localparam logic [15:0] LZ_HUND = 16'd100;
   localparam logic [15:0] LZ_TENS = 16'd10;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   // Scan order 4,3,[2],1,0 then back to the thousands digit.
   function automatic logic [2:0] next_slot(input logic [2:0] sel, input logic colon_en);
      case (sel)
         SEL_THOU:  return SEL_HUND;
         SEL_HUND:  return colon_en ? SEL_COLON : SEL_TENS;
         SEL_COLON: return SEL_TENS;
         SEL_TENS:  return SEL_ONES;
         default:   return SEL_THOU;
      endcase
   endfunction

   // A digit position is a leading zero when the value has no significant digit there.
   // The ones digit and the colon are never suppressed.
   function automatic logic lz_blank(input logic [2:0] sel, input logic [15:0] value);
      case (sel)
         SEL_THOU: return value < LZ_THOU;
         SEL_HUND: return value < LZ_HUND;
         SEL_TENS: return value < LZ_TENS;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] clamp_value(input logic [15:0] value);
      return (value > MAX_VALUE) ? MAX_VALUE : value;
   endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// rtl/scan_tick_counter.sv - phase tick counter counting 0..limit-1 with a wrap pulse
module scan_tick_counter #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] limit,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Wrap on the last count of the phase; the compare is >= so a shorter limit
   // loaded for the next phase can never leave the counter stranded above it.
   always_comb begin
      wrap    = (count_q >= (limit - WIDTH'(1)));
      count_d = wrap ? '0 : (count_q + WIDTH'(1));
   end

   // Counter register, restarted at zero by reset and by every wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit seven-segment scan sequencer with frame-aligned value loading
module display_scan_controller #(
   parameter int TICKS_PER_DIGIT = 2000,
   parameter int BLANK_TICKS     = 64,
   parameter int LZ_BLANK        = 1,
   parameter int COLON_EN        = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] displayValue,
   input  logic        valueValid,
   output logic        loadAck,
   output logic [15:0] activeValue,
   output logic [2:0]  digitSelect,
   input  logic [3:0]  digitValue,
   output logic [3:0]  segDigit,
   output logic [4:0]  digitEnable_n,
   output logic        colonOn,
   output logic        overflow,
   output logic        frameDone
);

   import display_pkg::*;

   localparam int CW = $clog2(TICKS_PER_DIGIT + 1);
   localparam logic [CW-1:0] BLANK_LIMIT = CW'(BLANK_TICKS);
   localparam logic [CW-1:0] SHOW_LIMIT  = CW'(TICKS_PER_DIGIT - BLANK_TICKS);
   localparam logic COLON_SCAN = (COLON_EN != 0);
   localparam logic LZ_ON      = (LZ_BLANK != 0);

   scan_state_e state_q, state_d;
   logic [2:0]  slot_q, slot_d;
   logic [15:0] active_q, active_d;
   logic [15:0] pend_val_q, pend_val_d;
   logic        pend_q, pend_d;
   logic        ovf_q, ovf_d;
   logic [3:0]  seg_q, seg_d;

   logic [CW-1:0] tick_limit;
   logic          tick_wrap;
   logic          frame_end;
   logic          commit;
   logic [15:0]   commit_src;

   // One counter serves both phases; the limit switches with the phase so the
   // wrap pulse marks the last cycle of the blank or show interval.
   assign tick_limit = (state_q == BLANK) ? BLANK_LIMIT : SHOW_LIMIT;

   scan_tick_counter #(
      .WIDTH (CW)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .limit (tick_limit),
      .wrap  (tick_wrap)
   );

   // Phase/slot sequencing: blank -> show within a slot, then move to the next slot.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      if (tick_wrap) begin
         if (state_q == BLANK) begin
            state_d = SHOW;
         end else begin
            state_d = BLANK;
            slot_d  = next_slot(slot_q, COLON_SCAN);
         end
      end
   end

   // Frame boundary and commit decision; an incoming value on the commit cycle wins over pending.
   always_comb begin
      frame_end  = (state_q == SHOW) && (slot_q == SEL_ONES) && tick_wrap;
      commit     = frame_end && (pend_q || valueValid);
      commit_src = valueValid ? displayValue : pend_val_q;
   end

   // Pending capture and snapshot commit with clamping to the displayable range.
   always_comb begin
      active_d   = active_q;
      ovf_d      = ovf_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      if (commit) begin
         active_d = clamp_value(commit_src);
         ovf_d    = (commit_src > MAX_VALUE);
         pend_d   = 1'b0;
      end else if (valueValid) begin
         pend_val_d = displayValue;
         pend_d     = 1'b1;
      end
   end

   // The parser digit is re-registered every cycle; the select settles at the
   // start of the blank phase, so the registered digit is stable before any enable.
   always_comb begin
      seg_d = digitValue;
   end

   // Enables are only driven in the show phase, and leading zeros stay dark.
   always_comb begin
      digitEnable_n = 5'b11111;
      if ((state_q == SHOW) && !(LZ_ON && lz_blank(slot_q, active_q))) begin
         digitEnable_n[slot_q] = 1'b0;
      end
   end

   // Sequencer and value registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= BLANK;
         slot_q     <= SEL_THOU;
         active_q   <= '0;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         ovf_q      <= 1'b0;
         seg_q      <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         active_q   <= active_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         seg_q      <= seg_d;
      end
   end

   assign digitSelect = slot_q;
   assign activeValue = active_q;
   assign segDigit    = seg_q;
   assign overflow    = ovf_q;
   assign colonOn     = (state_q == SHOW) && (slot_q == SEL_COLON);
   assign frameDone   = frame_end;
   assign loadAck     = commit;

endmodule
